// File: rtl/elevator_request_latch.sv
// Elevator call front end: synchronizes and debounces the three call buttons, then latches the
// selected floor bank into pending-request vectors that persist until the scheduler clears them.

module elevator_request_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          stable_dly_q;

    // Counter only advances while the synced level disagrees with the accepted level,
    // so any return to agreement restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            s1_q         <= raw_i;
            s2_q         <= s1_q;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = stable_q & ~stable_dly_q;
endmodule

module elevator_request_vec #(
    parameter int FLOORS     = 8,
    parameter int LATCH_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stable_i,
    input  logic              press_i,
    input  logic [FLOORS-1:0] sel_i,
    input  logic [FLOORS-1:0] mask_i,
    input  logic [FLOORS-1:0] clr_i,
    output logic [FLOORS-1:0] vec_o,
    output logic [FLOORS-1:0] vec_nxt_o
);
    logic [FLOORS-1:0] vec_q;
    logic [FLOORS-1:0] vec_d;
    logic [FLOORS-1:0] set_bits;

    // Set is OR'd after the clear so a same-cycle press of a served floor is not lost.
    always_comb begin
        set_bits = sel_i & mask_i;
        vec_d    = '0;
        if (LATCH_MODE != 0) begin
            vec_d = (vec_q & ~clr_i) | (press_i ? set_bits : '0);
        end else begin
            vec_d = stable_i ? set_bits : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o     = vec_q;
    assign vec_nxt_o = vec_d;
endmodule

module elevator_request_latch #(
    parameter int FLOORS          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LATCH_MODE      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*FLOORS-1:0] sw,
    input  logic                btnu,
    input  logic                btnd,
    input  logic                btnc,
    input  logic [FLOORS-1:0]   clr_up,
    input  logic [FLOORS-1:0]   clr_down,
    input  logic [FLOORS-1:0]   clr_car,
    output logic [FLOORS-1:0]   up,
    output logic [FLOORS-1:0]   down,
    output logic [FLOORS-1:0]   elevator_btn,
    output logic                req_pending
);
    localparam int NB = 3;

    logic [2*FLOORS-1:0]           sw_s1_q;
    logic [2*FLOORS-1:0]           sw_s2_q;
    logic [NB-1:0]                 btn_raw;
    logic [NB-1:0]                 stable;
    logic [NB-1:0]                 press;
    logic [NB-1:0][FLOORS-1:0]     sel;
    logic [NB-1:0][FLOORS-1:0]     mask;
    logic [NB-1:0][FLOORS-1:0]     clr;
    logic [NB-1:0][FLOORS-1:0]     vec;
    logic [NB-1:0][FLOORS-1:0]     vec_nxt;
    logic                          req_pending_q;
    logic                          req_pending_d;

    // Lane order: 0 = hall up, 1 = hall down, 2 = car.
    assign btn_raw = {btnc, btnd, btnu};
    assign clr     = {clr_car, clr_down, clr_up};

    assign sel[0] = sw_s2_q[2*FLOORS-1:FLOORS];
    assign sel[1] = sw_s2_q[2*FLOORS-1:FLOORS];
    assign sel[2] = sw_s2_q[FLOORS-1:0];

    // No hall-up call from the top floor, no hall-down call from the ground floor.
    assign mask[0] = ~(FLOORS'(1) << (FLOORS - 1));
    assign mask[1] = ~FLOORS'(1);
    assign mask[2] = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_lane
        elevator_request_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (btn_raw[g]),
            .stable_o (stable[g]),
            .press_o  (press[g])
        );

        elevator_request_vec #(
            .FLOORS     (FLOORS),
            .LATCH_MODE (LATCH_MODE)
        ) u_vec (
            .clk       (clk),
            .rst_n     (rst_n),
            .stable_i  (stable[g]),
            .press_i   (press[g]),
            .sel_i     (sel[g]),
            .mask_i    (mask[g]),
            .clr_i     (clr[g]),
            .vec_o     (vec[g]),
            .vec_nxt_o (vec_nxt[g])
        );
    end

    // Built from next-state so the flag rises and falls on the same edge as the vectors.
    assign req_pending_d = |vec_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pending_q <= 1'b0;
        end else begin
            req_pending_q <= req_pending_d;
        end
    end

    assign up           = vec[0];
    assign down         = vec[1];
    assign elevator_btn = vec[2];
    assign req_pending  = req_pending_q;
endmodule
